// File: rtl/ws2801_receiver.sv
// ws2801_receiver: WS2801 (CKI/SDI) pixel receiver.
// Oversamples CKI/SDI in the clk domain, captures the first 24 bits of a
// frame as an RGB word and latches it once CKI has stayed low for LATCH_US.
// Bits after the first 24 are forwarded on CKO/SDO for daisy-chaining.
// Optional feature macro: WS2801_RX_FWD_EN (forwarding logic); when it is
// undefined, cko/sdo are tied low and later bits are simply ignored.
module ws2801_receiver #(
  parameter int unsigned FREQ        = 100_000_000,
  parameter int unsigned LATCH_US    = 500,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cki,
  input  logic        sdi,
  output logic        cko,
  output logic        sdo,
  output logic [23:0] rgb,
  output logic        rgb_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned TIMEOUT = (FREQ / 1_000_000) * LATCH_US;
  localparam int unsigned CW      = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FORWARD = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] cki_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   cki_s;
  logic                   sdi_s;
  logic                   cki_q;
  logic                   rise;
  logic                   timeout;
  logic [CW-1:0]          idle_cnt;
  logic [4:0]             bit_cnt;
  logic [23:0]            shreg;
  logic                   shift_en;
  logic                   first_bit;
  logic                   latch;
  logic                   discard;

  assign cki_s   = cki_sync[SYNC_STAGES-1];
  assign sdi_s   = sdi_sync[SYNC_STAGES-1];
  assign rise    = cki_s & ~cki_q;
  assign timeout = ~cki_s & (idle_cnt == CW'(TIMEOUT));

  // Equal-depth synchronizers keep CKI and SDI aligned; one extra flop for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      cki_sync <= '0;
      sdi_sync <= '0;
      cki_q    <= 1'b0;
    end else begin
      cki_sync <= {cki_sync[SYNC_STAGES-2:0], cki};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cki_q    <= cki_s;
    end
  end

  // CKI-low duration counter, saturating at TIMEOUT (reset saturated: no spurious latch).
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= CW'(TIMEOUT);
    end else if (cki_s) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CW'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef WS2801_RX_FWD_EN
  logic fall;
  logic arm;
  logic fwd_arm;

  assign fall = ~cki_s & cki_q;
`endif

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    first_bit  = 1'b0;
    latch      = 1'b0;
    discard    = 1'b0;
    busy       = (state != IDLE);
`ifdef WS2801_RX_FWD_EN
    arm        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          shift_en   = 1'b1;
          first_bit  = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 5'd23) begin
            state_next = FORWARD;
          end
        end else if (timeout) begin
          if (bit_cnt == 5'd24) begin
            latch = 1'b1;
          end else begin
            discard = 1'b1;
          end
          state_next = IDLE;
        end
      end
      FORWARD: begin
        if (timeout) begin
          latch      = 1'b1;
          state_next = IDLE;
        end
`ifdef WS2801_RX_FWD_EN
        else if (fall) begin
          arm = 1'b1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture shift register, bit counter and latched output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      rgb       <= '0;
      rgb_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rgb_valid <= latch;
      frame_err <= discard;
      if (shift_en) begin
        shreg <= {shreg[22:0], sdi_s};
        if (first_bit) begin
          bit_cnt <= 5'd1;
        end else if (bit_cnt != 5'd24) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if (latch) begin
        rgb <= shreg;
      end
      if (latch || discard) begin
        bit_cnt <= '0;
      end
    end
  end

`ifdef WS2801_RX_FWD_EN
  // Forwarding is armed by the fall that ends bit 23, so that edge never reaches cko.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_arm <= 1'b0;
      cko     <= 1'b0;
      sdo     <= 1'b0;
    end else begin
      if (latch || discard) begin
        fwd_arm <= 1'b0;
      end else if (arm) begin
        fwd_arm <= 1'b1;
      end
      if (fwd_arm) begin
        cko <= cki_s;
        sdo <= sdi_s;
      end else begin
        cko <= 1'b0;
        sdo <= 1'b0;
      end
    end
  end
`else
  assign cko = 1'b0;
  assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_ws2801_receiver.sv
// Directed testbench for ws2801_receiver with a shortened latch interval.
module tb_ws2801_receiver;

  localparam int unsigned FREQ    = 100_000_000;
  localparam int unsigned LAT_US  = 2;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned TIMEOUT = (FREQ / 1_000_000) * LAT_US;

  logic        clk = 1'b0;
  logic        rst;
  logic        cki;
  logic        sdi;
  logic        cko;
  logic        sdo;
  logic [23:0] rgb;
  logic        rgb_valid;
  logic        frame_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  ws2801_receiver #(
    .FREQ       (FREQ),
    .LATCH_US   (LAT_US),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cki      (cki),
    .sdi      (sdi),
    .cko      (cko),
    .sdo      (sdo),
    .rgb      (rgb),
    .rgb_valid(rgb_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Monitors: sampled on the falling edge, away from the active edge.
  int          cyc       = 0;
  int          n_valid   = 0;
  int          n_err     = 0;
  int          n_cko     = 0;
  int          n_fwd_act = 0;
  int          valid_cyc = 0;
  int          t_fall    = 0;
  logic        cko_prev  = 1'b0;
  logic [23:0] sdo_sh    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rgb_valid) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (frame_err) n_err = n_err + 1;
    if (cko | sdo) n_fwd_act = n_fwd_act + 1;
    if (cko && !cko_prev) begin
      n_cko  = n_cko + 1;
      sdo_sh = {sdo_sh[22:0], sdo};
    end
    cko_prev = cko;
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // One WS2801 bit: SDI set-up with CKI low, 4-cycle high, 2-cycle low tail.
  task automatic send_bit(input logic b);
    sdi = b;
    wait_clk(2);
    cki = 1'b1;
    wait_clk(4);
    cki    = 1'b0;
    t_fall = cyc;
    wait_clk(2);
  endtask

  task automatic send_bits(input logic [47:0] v, input int unsigned n);
    for (int unsigned i = n; i > 0; i--) begin
      send_bit(v[i-1]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cki = 1'b0;
    sdi = 1'b0;
    wait_clk(5);
    n_checks += 6;
    if (rgb !== 24'h0)     begin n_fail++; $display("FAIL reset_rgb got %h want 000000", rgb); end
    if (rgb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rgb_valid); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", frame_err); end
    if (cko !== 1'b0)       begin n_fail++; $display("FAIL reset_cko got %b want 0", cko); end
    if (sdo !== 1'b0)       begin n_fail++; $display("FAIL reset_sdo got %b want 0", sdo); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    wait_clk(TIMEOUT + 20);
  endtask

  task automatic test_single_frame;
    int v0, e0, c0, lat;
    v0 = n_valid; e0 = n_err; c0 = n_cko;
    send_bits(48'h800000, 24);
    n_checks += 1;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid got %b want 1", busy); end
    wait_clk(TIMEOUT + 50);
    lat = valid_cyc - t_fall;
    n_checks += 6;
    if (rgb !== 24'h800000)  begin n_fail++; $display("FAIL single_rgb got %h want 800000", rgb); end
    if (n_valid - v0 !== 1)  begin n_fail++; $display("FAIL single_valid_cnt got %0d want 1", n_valid - v0); end
    if (n_err - e0 !== 0)    begin n_fail++; $display("FAIL single_err_cnt got %0d want 0", n_err - e0); end
    if (n_cko - c0 !== 0)    begin n_fail++; $display("FAIL single_cko_edges got %0d want 0", n_cko - c0); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL single_busy_end got %b want 0", busy); end
    if (lat < int'(SYNC + TIMEOUT) - 1 || lat > int'(SYNC + TIMEOUT) + 1) begin
      n_fail++;
      $display("FAIL single_latency got %0d want %0d..%0d", lat, SYNC + TIMEOUT - 1, SYNC + TIMEOUT + 1);
    end
  endtask

  task automatic test_chain;
    int v0, c0, a0;
    v0 = n_valid; c0 = n_cko; a0 = n_fwd_act;
    sdo_sh = '0;
    send_bits(48'hA5A5A5_123456, 48);
    wait_clk(TIMEOUT + 50);
    n_checks += 2;
    if (rgb !== 24'hA5A5A5) begin n_fail++; $display("FAIL chain_rgb got %h want a5a5a5", rgb); end
    if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL chain_valid_cnt got %0d want 1", n_valid - v0); end
`ifdef WS2801_RX_FWD_EN
    n_checks += 2;
    if (n_cko - c0 !== 24)   begin n_fail++; $display("FAIL chain_cko_edges got %0d want 24", n_cko - c0); end
    if (sdo_sh !== 24'h123456) begin n_fail++; $display("FAIL chain_sdo got %h want 123456", sdo_sh); end
`else
    n_checks += 2;
    if (n_cko - c0 !== 0)       begin n_fail++; $display("FAIL chain_cko_edges got %0d want 0", n_cko - c0); end
    if (n_fwd_act - a0 !== 0)   begin n_fail++; $display("FAIL chain_fwd_activity got %0d want 0", n_fwd_act - a0); end
`endif
  endtask

  task automatic test_frame_err;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_bits(48'h2B5, 10);
    wait_clk(TIMEOUT + 50);
    n_checks += 4;
    if (n_err - e0 !== 1)   begin n_fail++; $display("FAIL err_cnt got %0d want 1", n_err - e0); end
    if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL err_valid_cnt got %0d want 0", n_valid - v0); end
    if (rgb !== 24'hA5A5A5) begin n_fail++; $display("FAIL err_rgb_kept got %h want a5a5a5", rgb); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL err_busy got %b want 0", busy); end
  endtask

  task automatic test_gap;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_bits(48'h0F0, 12);
    // 2 tail + (TIMEOUT-6) + 2 set-up of next bit + ~0 = TIMEOUT-2 low cycles
    wait_clk(TIMEOUT - 6);
    send_bits(48'hF0F, 12);
    n_checks += 2;
    if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL gap_valid_mid got %0d want 0", n_valid - v0); end
    if (n_err - e0 !== 0)   begin n_fail++; $display("FAIL gap_err_mid got %0d want 0", n_err - e0); end
    wait_clk(TIMEOUT + 50);
    n_checks += 2;
    if (rgb !== 24'h0F0F0F) begin n_fail++; $display("FAIL gap_rgb got %h want 0f0f0f", rgb); end
    if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL gap_valid_cnt got %0d want 1", n_valid - v0); end
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    send_bits(48'hBEEF, 16);
    rst = 1'b1;
    wait_clk(3);
    n_checks += 6;
    if (rgb !== 24'h0)      begin n_fail++; $display("FAIL rmid_rgb got %h want 000000", rgb); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    if (rgb_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", rgb_valid); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rmid_err got %b want 0", frame_err); end
    if (cko !== 1'b0)       begin n_fail++; $display("FAIL rmid_cko got %b want 0", cko); end
    if (sdo !== 1'b0)       begin n_fail++; $display("FAIL rmid_sdo got %b want 0", sdo); end
    rst = 1'b0;
    v0 = n_valid; e0 = n_err;
    wait_clk(TIMEOUT + 50);
    n_checks += 1;
    if (n_err - e0 !== 0) begin n_fail++; $display("FAIL rmid_no_err got %0d want 0", n_err - e0); end
    send_bits(48'hFFFFFF, 24);
    wait_clk(TIMEOUT + 50);
    n_checks += 2;
    if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL rmid_rgb_after got %h want ffffff", rgb); end
    if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL rmid_valid_cnt got %0d want 1", n_valid - v0); end
  endtask

  task automatic test_cki_stuck_high;
    int v0;
    v0 = n_valid;
    send_bits(48'h00C3C3, 23);
    sdi = 1'b1;
    wait_clk(2);
    cki = 1'b1;
    wait_clk(3 * TIMEOUT);
    n_checks += 1;
    if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL stuck_high_valid got %0d want 0", n_valid - v0); end
    cki = 1'b0;
    wait_clk(TIMEOUT + 50);
    n_checks += 2;
    if (n_valid - v0 !== 1)  begin n_fail++; $display("FAIL stuck_release_valid got %0d want 1", n_valid - v0); end
    if (rgb !== 24'h018787)  begin n_fail++; $display("FAIL stuck_rgb got %h want 018787", rgb); end
  endtask

  initial begin
    rst = 1'b1;
    cki = 1'b0;
    sdi = 1'b0;
    test_reset;
    test_single_frame;
    test_chain;
    test_frame_err;
    test_gap;
    test_reset_mid;
    test_cki_stuck_high;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
